// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, baud divisor and frame-length helpers shared by
// the UART transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned START_BITS = 1;
  // Start + data + one stop bit; parity and a second stop bit add to this.
  localparam int unsigned FRAME_BITS_BASE = START_BITS + DATA_BITS + 1;

  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int unsigned frame_bits(input int unsigned stop_bits,
                                             input bit          parity_en);
    return FRAME_BITS_BASE + (stop_bits - 1) + (parity_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running bit-period counter with synchronous clear and a
// one-cycle tick on the last count of each period.
module uart_baud_gen #(
  parameter int unsigned DIV = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter, LSB first, STOP_BITS stop bits, idle-high line.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1).
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
  localparam bit CFG_OK = (STOP_BITS == 1 || STOP_BITS == 2) &&
                          (PARITY_ODD <= 1) && (BAUD_DIV >= 1);

  if (!CFG_OK) begin : g_bad_cfg
    $error("uart_tx: illegal STOP_BITS/PARITY_ODD/baud configuration");
  end

  uart_state_t state, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx, bit_idx_d;
  logic        tx_d;
  logic        done_d;
  logic        accept;
  logic        tick;

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_INIT = (PARITY_ODD != 0);
  logic parity_q, parity_d;
`endif

  assign accept = data_valid && data_ready;

  // Holding the counter clear through IDLE makes every frame start at phase 0.
  uart_baud_gen #(
    .DIV (BAUD_DIV)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (state == IDLE),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state;
    shift_d   = shift_q;
    bit_idx_d = bit_idx;
    tx_d      = tx;
    done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state)
      IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d   = START;
          shift_d   = data_in;
          bit_idx_d = '0;
          tx_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d  = (^data_in) ^ PARITY_INIT;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == 3'd7) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
            tx_d      = parity_q;
`else
            state_d   = STOP;
            tx_d      = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        // bit_idx is reused here to count stop bits.
        if (tick) begin
          if (bit_idx == STOP_LAST) begin
            state_d   = IDLE;
            bit_idx_d = '0;
            done_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        bit_idx_d = '0;
        tx_d      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift_q    <= '0;
      bit_idx    <= '0;
      tx         <= 1'b1;
      tx_done    <= 1'b0;
      data_ready <= 1'b1;
      tx_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      shift_q    <= shift_d;
      bit_idx    <= bit_idx_d;
      tx         <= tx_d;
      tx_done    <= done_d;
      data_ready <= (state_d == IDLE);
      tx_busy    <= (state_d != IDLE);
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate in bits/s.
REQ-003 Parameter STOP_BITS, default 1, number of stop bits (legal values 1 or 2).
REQ-004 Parameter PARITY_ODD, default 0, parity sense when parity is compiled in (0 = even, 1 = odd).
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 data_in  input  8  byte to transmit; sampled only on the accept cycle.
REQ-008 data_valid  input  1  request to send data_in.
REQ-009 data_ready  output  1  high when a byte can be accepted.
REQ-010 tx  output  1  serial line; idle high.
REQ-011 tx_busy  output  1  high while a frame is on the line.
REQ-012 tx_done  output  1  one-cycle pulse at the end of each frame.

Function
REQ-013 BAUD_DIV = CLK_FREQ/BAUD_RATE (integer division); every line bit lasts exactly BAUD_DIV clk cycles.
REQ-014 FSM states: IDLE, START, DATA, PARITY, STOP; PARITY is reachable only when parity is compiled in.
REQ-015 Accept occurs on a cycle with data_valid=1 and data_ready=1; data_in is latched into a shift register and the FSM enters START.
REQ-016 tx goes low on the cycle after accept; the baud counter restarts from 0 at accept, with no phase carried from any prior frame.
REQ-017 DATA state sends 8 bits LSB first; the bit index counts 0..7, then the FSM moves to PARITY or STOP.
REQ-018 STOP drives tx=1 for STOP_BITS*BAUD_DIV cycles, then the FSM enters IDLE.
REQ-019 tx_done is high for exactly one cycle, on the first IDLE cycle after STOP.
REQ-020 data_ready equals (state==IDLE) and tx_busy equals (state!=IDLE); both are registered and mutually exclusive.
REQ-021 With data_valid held high, the next byte is accepted on the tx_done cycle; the inter-frame gap is exactly 1 idle-high cycle beyond the stop bit(s).
REQ-022 data_valid or data_in changes while busy are ignored; there is no queueing, and the in-flight frame is unaffected.
REQ-023 tx is driven from a register (glitch-free); no combinational path exists from any input to tx.

Reset
REQ-024 Reset values: tx=1, data_ready=1, tx_busy=0, tx_done=0, state=IDLE, baud counter=0, bit index=0.
REQ-025 Reset asserted mid-frame abandons the frame; tx is high on the next edge, and no tx_done is generated.
REQ-026 A data_valid asserted in the same cycle as rst is not accepted.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: a parity bit (XOR of data, inverted when PARITY_ODD=1) is sent between the last data bit and STOP; the frame is 11 or 12 bits.
REQ-028 Macro UART_TX_PARITY_EN undefined: there is no PARITY state and no parity logic; the frame is 10 or 11 bits; PARITY_ODD has no effect.

Structure
REQ-029 Package uart_pkg holds the FSM state typedef, the BAUD_DIV computation function, and the frame-length constants; it is shared with the receiver.
REQ-030 Sub-module uart_baud_gen holds the baud counter (clear input, one-cycle tick output at count BAUD_DIV-1); it is reusable by the receiver.

Verification (CLK_FREQ=50000000, BAUD_RATE=115200, BAUD_DIV=434, STOP_BITS=1)
REQ-031 Send 0x55, no parity -> tx sequence 0,1,0,1,0,1,0,1,0,1; each bit 434 cycles; tx_done 4340 cycles after the first low cycle.
REQ-032 data_valid held high with 0xA5 then 0x3C -> two frames separated by exactly 1 idle-high cycle after the stop bit; exactly two tx_done pulses.
REQ-033 Parity enabled, even: 0x07 -> parity bit 1; 0x55 -> parity bit 0. Parity enabled, PARITY_ODD=1: 0x07 -> parity bit 0. Frame length 4774 cycles.
REQ-034 rst pulsed 2000 cycles into a frame -> tx=1 and data_ready=1 on the next edge; no tx_done; the next accepted byte transmits correctly.
REQ-035 data_in toggled and data_valid pulsed while tx_busy=1 -> the frame on the line is unchanged; no extra frame follows.
